// File: rtl/nios2_oci_trace_fifo_if.sv
// Trace FIFO bus: trace generator frames in, PIB-side frame and status out.
// Optional almost-full status is present only with NIOS2_OCI_FIFO_AFULL_EN.
interface nios2_oci_trace_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          trc_on;
  logic [35:0]   itm;
  logic [35:0]   atm;
  logic [35:0]   dtm;
  logic          ovf_clr;
  logic [35:0]   tw;
  logic [CW-1:0] fifo_cnt;
  logic          ovf_sticky;
`ifdef NIOS2_OCI_FIFO_AFULL_EN
  logic          afull;
`endif

  // Trace source / observer side.
  modport master (
    output trc_on, itm, atm, dtm, ovf_clr,
`ifdef NIOS2_OCI_FIFO_AFULL_EN
    input  afull,
`endif
    input  tw, fifo_cnt, ovf_sticky
  );

  // FIFO side.
  modport slave (
    input  trc_on, itm, atm, dtm, ovf_clr,
`ifdef NIOS2_OCI_FIFO_AFULL_EN
    output afull,
`endif
    output tw, fifo_cnt, ovf_sticky
  );
endinterface

// File: rtl/nios2_oci_trace_fifo.sv
// Trace-word FIFO feeding the OCI PIB stage. Accepts up to three 36-bit
// frames per clk (itm, atm, dtm), emits one frame per clk on tw.
// On overrun a whole cycle's frames are dropped and a marker frame
// {OVF_TYPE, 16'h0, drop_cnt} is inserted once room exists.
// Optional macro NIOS2_OCI_FIFO_AFULL_EN adds the registered afull output.
module nios2_oci_trace_fifo #(
  parameter int         DEPTH    = 16,
  parameter logic [3:0] OVF_TYPE = 4'hF
) (
  input  logic                   clk,
  input  logic                   jrst,
  nios2_oci_trace_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [35:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [35:0]   tw_q;
  logic          ovf_pending_q, ovf_pending_d;
  logic          ovf_sticky_q, ovf_sticky_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
`ifdef NIOS2_OCI_FIFO_AFULL_EN
  logic          afull_q;
`endif

  // Write candidates in slot order: marker, itm, atm, dtm.
  logic [35:0]   cand [4];
  logic [3:0]    cand_vld;
  logic [3:0]    wen;
  logic [AW-1:0] off [4];

  assign cand[0] = {OVF_TYPE, 16'h0, drop_cnt_q};
  assign cand[1] = bus.itm;
  assign cand[2] = bus.atm;
  assign cand[3] = bus.dtm;
  assign cand_vld[0] = ovf_pending_q;

  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_vld
      assign cand_vld[gi] = bus.trc_on && (cand[gi][35:32] != 4'h0);
    end
    // Each accepted frame lands right after the previously accepted one.
    assign off[0] = '0;
    for (gi = 1; gi < 4; gi++) begin : g_off
      assign off[gi] = off[gi-1] + AW'(wen[gi-1]);
    end
  endgenerate

  logic          rd_en;
  logic [1:0]    n_in;
  logic [2:0]    n_wr;
  logic [CW:0]   free;
  logic [CW:0]   need;
  logic          accept;
  logic [16:0]   drop_sum;

  // Space check and overflow bookkeeping for this cycle.
  always_comb begin
    rd_en         = (cnt_q != '0);
    n_in          = 2'(cand_vld[1]) + 2'(cand_vld[2]) + 2'(cand_vld[3]);
    free          = (CW+1)'(DEPTH) - {1'b0, cnt_q} + (CW+1)'(rd_en);
    need          = (CW+1)'(n_in) + (CW+1)'(ovf_pending_q);
    accept        = (need <= free);
    drop_sum      = {1'b0, drop_cnt_q} + 17'(n_in);
    wen           = accept ? cand_vld : 4'b0000;
    n_wr          = accept ? (3'(n_in) + 3'(ovf_pending_q)) : 3'd0;
    ovf_pending_d = ovf_pending_q;
    drop_cnt_d    = drop_cnt_q;
    ovf_sticky_d  = bus.ovf_clr ? 1'b0 : ovf_sticky_q;
    if (accept) begin
      if (ovf_pending_q) begin
        ovf_pending_d = 1'b0;
        drop_cnt_d    = 16'h0;
      end
    end else begin
      // Whole cycle dropped; never a partial write.
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (n_in != 2'd0) begin
        ovf_pending_d = 1'b1;
        ovf_sticky_d  = 1'b1;
      end
    end
    cnt_d = cnt_q - CW'(rd_en) + CW'(n_wr);
  end

  // Frame storage: up to four writes at consecutive (wrapping) slots.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wen[k]) mem[wr_ptr_q + off[k]] <= cand[k];
    end
  end

  // Pointers, occupancy, output frame and overflow state.
  always_ff @(posedge clk) begin
    if (jrst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      tw_q          <= 36'h0;
      ovf_pending_q <= 1'b0;
      ovf_sticky_q  <= 1'b0;
      drop_cnt_q    <= 16'h0;
    end else begin
      tw_q          <= rd_en ? mem[rd_ptr_q] : 36'h0;
      rd_ptr_q      <= rd_ptr_q + AW'(rd_en);
      wr_ptr_q      <= wr_ptr_q + AW'(n_wr);
      cnt_q         <= cnt_d;
      ovf_pending_q <= ovf_pending_d;
      ovf_sticky_q  <= ovf_sticky_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef NIOS2_OCI_FIFO_AFULL_EN
  // Flags that a three-frame burst might not fit next cycle.
  always_ff @(posedge clk) begin
    if (jrst) afull_q <= 1'b0;
    else      afull_q <= (cnt_d >= CW'(DEPTH - 3));
  end
  assign bus.afull = afull_q;
`endif

  assign bus.tw         = tw_q;
  assign bus.fifo_cnt   = cnt_q;
  assign bus.ovf_sticky = ovf_sticky_q;
endmodule

// File: doc/nios2_oci_trace_fifo.md
Name: nios2_oci_trace_fifo

Overview:
- Trace-word FIFO directly upstream of the OCI PIB trace port stage.
- Collects up to three 36-bit trace frames per clk from the instruction, address and data trace generators (itm/atm/dtm), buffers them, and presents one frame per clk on tw.
- The PIB serialises tw as two 18-bit halves on clkx2.
- When the buffer overruns, incoming frames are dropped and an overflow marker frame carrying the drop count is inserted.

Parameters:
- DEPTH, 16: number of 36-bit entries; power of 2, >= 4.
- OVF_TYPE, 4'hF: type nibble placed in tw[35:32] of the overflow marker frame.

Ports:
- clk  in  1  single clock; all state on posedge.
- jrst  in  1  synchronous, active-high reset.
- trc_on  in  1  trace enable; 0 = all incoming frames ignored (not counted as drops).
- itm  in  36  instruction trace frame; valid when itm[35:32] != 0.
- atm  in  36  address trace frame; valid when atm[35:32] != 0.
- dtm  in  36  data trace frame; valid when dtm[35:32] != 0.
- ovf_clr  in  1  clears ovf_sticky.
- tw  out  36  registered frame to PIB; 36'h0 = idle.
- fifo_cnt  out  clog2(DEPTH)+1  registered occupancy.
- ovf_sticky  out  1  set on any drop; held until ovf_clr.

Behaviour:
- Reset (jrst=1 at posedge): rd/wr pointers, fifo_cnt, tw, ovf_sticky, ovf_pending and drop_cnt all = 0. Memory contents need not be cleared. Reset mid-operation discards all buffered frames and any pending marker.
- n_in = number of valid frames among itm/atm/dtm, 0..3, forced to 0 when trc_on=0.
- Read, each cycle:
  - rd_en = (fifo_cnt != 0).
  - If rd_en: tw <= mem[rd_ptr] and rd_ptr++. Otherwise tw <= 0.
  - One frame per clk; no backpressure from the PIB.
- free = DEPTH - fifo_cnt + rd_en. The slot freed by this cycle's read is reusable in the same cycle.
- Write order within a cycle:
  1. Overflow marker, if written.
  2. itm.
  3. atm.
  4. dtm.
  - Invalid frames are skipped with no gaps, into consecutive slots from wr_ptr.
  - Pointers wrap modulo DEPTH.
- Normal case (ovf_pending=0, n_in <= free): write n_in frames.
- Overflow case (n_in > free), or ovf_pending=1 with free < 1 + n_in:
  - Write nothing; all n_in frames of the cycle are dropped (never partial).
  - drop_cnt += n_in, saturating at 16'hFFFF.
  - If n_in > 0: ovf_pending <= 1 and ovf_sticky <= 1.
- Marker (ovf_pending=1 and free >= 1 + n_in):
  - Write marker {OVF_TYPE, 16'h0, drop_cnt} first, then the n_in frames.
  - drop_cnt <= 0 and ovf_pending <= 0.
  - A marker is written even when trc_on=0 (n_in=0) once space exists.
- fifo_cnt_next = fifo_cnt - rd_en + writes (writes includes the marker). fifo_cnt never exceeds DEPTH.
- Latency: a frame written at edge N appears on tw at edge N+1 at the earliest (FIFO empty).
- ovf_sticky: set has priority over ovf_clr in the same cycle. ovf_clr alone clears it at the next edge.

Optional Feature:
- Macro: NIOS2_OCI_FIFO_AFULL_EN.
- Defined: adds output port afull (1 bit, registered, reset 0). afull=1 when fifo_cnt_next >= DEPTH-3, i.e. a 3-frame burst may not fit next cycle.
- Undefined: port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, trc_on=1, itm=36'h1_0000_1234 for one cycle, atm=dtm=0 -> tw=36'h1_0000_1234 one edge after capture, then tw=0; fifo_cnt 0->1->0.
- One cycle with itm=36'h1_0000_000A, atm=36'h2_0000_000B, dtm=36'h3_0000_000C -> tw = A, B, C on three consecutive cycles, then 0.
- DEPTH=8, all three frames valid for 4 cycles, then idle:
  - Cycles 1-3 accepted (fifo_cnt 3, 5, 7).
  - Cycle 4 dropped (free=2 < 3).
  - Cycle 5 writes marker.
  - tw shows 9 data frames then 36'hF_0000_0003; ovf_sticky=1.
- ovf_clr=1 in the same cycle as a drop -> ovf_sticky stays 1. ovf_clr=1 in an idle cycle -> ovf_sticky=0 next edge.
- trc_on=0 with valid itm/atm/dtm, plus trc_on=1 with itm[35:32]=0 -> no writes, tw stays 0, ovf_sticky stays 0.
- jrst=1 while fifo_cnt=5 and ovf_pending=1 -> next edge tw=0, fifo_cnt=0, and no marker ever emitted afterwards.
